// File: rtl/pc_seq_pkg.sv
// Shared types and sizing for the fetch-stage PC sequencer.
// State encoding, PC width, LUT index width and return-stack depth.
package pc_seq_pkg;

  localparam int PC_W        = 10;
  localparam int LUT_IDX_W   = 8;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Registered LIFO of return addresses for call/return.
// Ports: clk, reset, clear, push, pop, din, dout (top entry), full, empty.
module pc_ret_stack #(
  parameter int D     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [D-1:0] mem [DEPTH];
  logic [AW:0]  sp;
  logic [AW:0]  spm1;

  assign spm1  = sp - 1'b1;
  assign full  = (sp == (AW+1)'(DEPTH));
  assign empty = (sp == '0);
  assign dout  = mem[spm1[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= spm1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && push && !full) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: IDLE/RUN/DONE FSM, PC_LUT redirects,
// sticky wrap/stack errors. Ports: clk, reset, start, stall, halt,
// branch_en, call, ret, branch_idx, lut_addr, lut_target, pc,
// running, done, wrap_err, stk_err. PC_SEQ_CALL_STACK_EN adds a
// return-address stack; without it call acts as a branch and ret
// as a plain increment.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D           = PC_W,
  parameter int STACK_DEPTH = pc_seq_pkg::STACK_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch_en,
  input  logic                 call,
  input  logic                 ret,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [LUT_IDX_W-1:0] lut_addr,
  input  logic [D-1:0]         lut_target,
  output logic [D-1:0]         pc,
  output logic                 running,
  output logic                 done,
  output logic                 wrap_err,
  output logic                 stk_err
);

  state_t       state;
  state_t       state_n;
  logic [D-1:0] pc_n;
  logic [D-1:0] pc_inc;
  logic         wrap_set;
  logic         clr;
  logic         act;

  assign lut_addr = branch_idx;
  assign pc_inc   = pc + D'(1);
  assign clr      = (state == DONE) && start;
  assign act      = (state == RUN) && !halt && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (halt)  state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
  end

`ifdef PC_SEQ_CALL_STACK_EN
  logic         push;
  logic         pop;
  logic         stk_set;
  logic         stk_full;
  logic         stk_empty;
  logic [D-1:0] stk_top;

  pc_ret_stack #(
    .D     (D),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .clear (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    pc_n     = pc;
    wrap_set = 1'b0;
    stk_set  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (clr) begin
      pc_n = '0;
    end else if (act) begin
      if (ret) begin
        if (!stk_empty) begin
          pc_n = stk_top;
          pop  = 1'b1;
        end else begin
          pc_n     = pc_inc;
          wrap_set = &pc;
          stk_set  = 1'b1;
        end
      end else if (call) begin
        pc_n = lut_target;
        // Full stack: still redirect, drop the push.
        if (stk_full) stk_set = 1'b1;
        else          push    = 1'b1;
      end else if (branch_en) begin
        pc_n = lut_target;
      end else begin
        pc_n     = pc_inc;
        wrap_set = &pc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    stk_err <= 1'b0;
    else if (clr) stk_err <= 1'b0;
    else          stk_err <= stk_err | stk_set;
  end
`else
  always_comb begin
    pc_n     = pc;
    wrap_set = 1'b0;
    if (clr) begin
      pc_n = '0;
    end else if (act) begin
      // No stack: ret is a plain step, call is a branch.
      if (ret) begin
        pc_n     = pc_inc;
        wrap_set = &pc;
      end else if (call || branch_en) begin
        pc_n = lut_target;
      end else begin
        pc_n     = pc_inc;
        wrap_set = &pc;
      end
    end
  end

  // Without a stack no stack error can occur.
  assign stk_err = (STACK_DEPTH < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      wrap_err <= 1'b0;
    end else begin
      pc <= pc_n;
      if (clr) wrap_err <= 1'b0;
      else     wrap_err <= wrap_err | wrap_set;
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the fetch stage; owns the PC register and sequences PC_LUT.
- Drives the LUT index for taken branches and calls, consumes the LUT target, and provides start/halt control.
- Optionally maintains a small return-address stack for call/return.
- Sits between the decoder/branch-condition logic and instruction memory.

Parameters:
- D, 10, PC width in bits; must match PC_LUT's D.
- STACK_DEPTH, 4, return-stack entries (power of 2, ≥2); used only when the macro is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; IDLE→RUN.
- stall  in  1  hold PC this cycle.
- halt  in  1  decoded halt instruction; RUN→DONE.
- branch_en  in  1  taken branch (condition already resolved by decoder).
- call  in  1  call instruction (branch via LUT and push return address).
- ret  in  1  return instruction (pop return address).
- branch_idx  in  8  LUT index from the instruction.
- lut_addr  out  8  to PC_LUT addr; combinational copy of branch_idx.
- lut_target  in  D  from PC_LUT target.
- pc  out  D  current PC, registered.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- wrap_err  out  1  sticky; PC incremented past 2^D-1.
- stk_err  out  1  sticky; push when full or pop when empty.

Behaviour:
- Reset (async): state=IDLE, pc=0, running=0, done=0, wrap_err=0, stk_err=0, stack pointer=0.
- FSM states:
  - IDLE: pc holds. start=1 → RUN on the next edge; pc stays 0.
  - RUN: per-cycle update using the priority list below.
  - DONE: pc frozen, done=1; all inputs except start are ignored. start=1 → RUN with pc=0, sticky errors cleared, stack cleared.
- RUN priority, highest first, one action per edge:
  1. halt → DONE, pc unchanged.
  2. stall → pc unchanged. Any simultaneous branch/call/ret is dropped; the decoder re-presents it.
  3. ret → pc = popped address.
  4. call → pc = lut_target; push pc+1.
  5. branch_en → pc = lut_target.
  6. Otherwise → pc = pc+1.
- Control inputs outside RUN have no effect.
- Latency: PC_LUT is combinational, so a redirect takes effect in one cycle; pc shows the target on the edge after branch_en is sampled.
- Width/arithmetic:
  - pc+1 is modulo 2^D. Increment from 2^D-1 gives 0 and sets wrap_err.
  - Redirects never set wrap_err.
- lut_target == 0 is legal (default LUT entry); branch to 0 is taken normally.
- lut_addr is driven in every state.

Optional Feature:
- Macro: PC_SEQ_CALL_STACK_EN.
- Defined (LIFO of STACK_DEPTH × D bits):
  - call pushes pc+1 modulo 2^D (no wrap_err on the push value).
  - Call while full: still branches, push dropped, stk_err=1.
  - ret while empty: pc = pc+1, stk_err=1.
  - Simultaneous call+ret: ret wins per the priority list; call is dropped.
- Undefined:
  - no stack storage;
  - call behaves as branch_en;
  - ret behaves as a plain increment;
  - stk_err tied 0.

Decomposition:
- Package pc_seq_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit;
  - PC_W default 10;
  - LUT_IDX_W = 8;
  - STACK_DEPTH default 4.
- One sub-module, pc_ret_stack:
  - registered LIFO with push/pop/full/empty;
  - instantiated only under PC_SEQ_CALL_STACK_EN.

Test Plan (bench instantiates PC_LUT):
- Reset then start, 5 plain cycles → pc 0,1,2,3,4,5; running=1; assert reset mid-run → pc=0, state IDLE immediately.
- branch_en=1, branch_idx=2 at pc=6 → next pc=285; branch_idx=15 → next pc=0.
- stall=1 with branch_en=1, idx=3 → pc held one cycle; stall released, branch re-presented → pc=267.
- halt at pc=9 → done=1, pc stays 9 for 10 cycles despite branch_en; start → pc=0, running=1.
- Force pc to 1023 via a LUT stub, then increment → pc=0, wrap_err=1, stays set until start from DONE.
- With macro: call idx=16 at pc=40 → pc=35; ret → pc=41. Five nested calls → stk_err=1 on the fifth push. ret on empty → pc+1, stk_err=1. Without macro: same call → pc=35, ret → 36.
